// File: rtl/nand_dff.sv
// Positive-edge D flip-flop with synchronous active-high reset.
// WIDTH independent bits share clk and rst; q powers up at RESET_VALUE.
module nand_dff #(
   parameter int unsigned           WIDTH       = 1,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Declaration initialiser gives the defined power-up value before the first edge
   logic [WIDTH-1:0] q_q = RESET_VALUE;
   logic [WIDTH-1:0] q_d;

   // Reset overrides data; a data X with rst=1 never reaches q
   always_comb begin
      q_d = d;
      if (rst) begin
         q_d = RESET_VALUE;
      end
   end

   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: tb/tb_nand_dff.sv
// Scoreboard bench for nand_dff: a 1-bit default instance and an 8-bit
// instance with RESET_VALUE 8'hA5 run side by side on one clock.
module tb_nand_dff;

   logic       clk;
   logic       rst1;
   logic       d1;
   logic       q1;
   logic       rst8;
   logic [7:0] d8;
   logic [7:0] q8;

   logic       sb1[$];
   logic [7:0] sb8[$];
   logic       m1;
   logic [7:0] m8;

   int n_vec;
   int n_err;

   nand_dff u_dut1 (
      .clk (clk),
      .rst (rst1),
      .d   (d1),
      .q   (q1)
   );

   nand_dff #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dut8 (
      .clk (clk),
      .rst (rst8),
      .d   (d8),
      .q   (q8)
   );

   // First rising edge at t=50, period 20
   initial begin
      clk = 1'b0;
      #40;
      forever #10 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, act, exp, $time);
      end
   endtask

   // Drive in the low phase; q must hold through the falling edge and the input change
   task automatic drive(input logic d1_v, input logic r1_v,
                        input logic [7:0] d8_v, input logic r8_v);
      @(negedge clk);
      #1;
      check("hold1_fall", q1, m1);
      check("hold8_fall", q8, m8);
      #1;
      d1   = d1_v;
      rst1 = r1_v;
      d8   = d8_v;
      rst8 = r8_v;
      #1;
      check("hold1_low", q1, m1);
      check("hold8_low", q8, m8);
      sb1.push_back(r1_v ? 1'b0 : d1_v);
      sb8.push_back(r8_v ? 8'hA5 : d8_v);
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
      if (sb1.size() == 0 || sb8.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_empty: got empty queue expected pending entry");
      end else begin
         m1 = sb1.pop_front();
         m8 = sb8.pop_front();
         check("q1_edge", q1, m1);
         check("q8_edge", q8, m8);
      end
   endtask

   task automatic step(input logic d1_v, input logic r1_v,
                       input logic [7:0] d8_v, input logic r8_v);
      drive(d1_v, r1_v, d8_v, r8_v);
      sample();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m1    = 1'b0;
      m8    = 8'hA5;
      d1    = 1'b0;
      rst1  = 1'b0;
      d8    = 8'h00;
      rst8  = 1'b1;
      sb1.push_back(1'b0);
      sb8.push_back(8'hA5);
      #1;
      check("q1_powerup", q1, 1'b0);
      check("q8_powerup", q8, 8'hA5);
      sample();

      // Capture, then hold with d=1, then d=0 captured on the following edge
      step(1'b1, 1'b0, 8'h3C, 1'b0);
      step(1'b1, 1'b0, 8'h3C, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // Sync reset with d=1 wins; release captures immediately
      step(1'b1, 1'b0, 8'h3C, 1'b0);
      step(1'b1, 1'b1, 8'hFF, 1'b1);
      step(1'b1, 1'b0, 8'h5A, 1'b0);

      // Glitches on d and rst while clk is high must not disturb q
      d1 = 1'b0; d8 = 8'h00;
      #2; check("glitch1_a", q1, m1); check("glitch8_a", q8, m8);
      d1 = 1'b1; d8 = 8'hFF; rst1 = 1'b1; rst8 = 1'b1;
      #2; check("glitch1_b", q1, m1); check("glitch8_b", q8, m8);
      d1 = 1'b0; d8 = 8'h00; rst1 = 1'b0; rst8 = 1'b0;
      #2; check("glitch1_c", q1, m1); check("glitch8_c", q8, m8);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // 8-bit reset / capture / reset sequence
      step(1'b1, 1'b0, 8'h3C, 1'b1);
      step(1'b0, 1'b0, 8'h3C, 1'b0);
      step(1'b1, 1'b0, 8'h3C, 1'b1);

      for (int i = 0; i < 24; i++) begin
         step(1'($urandom), 1'($urandom_range(0, 3) == 0),
              8'($urandom), 1'($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
